fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the five-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Consumes the ID-stage branch decision (PCSrc, branch target) and the hazard-unit stall.
- Drives the instruction-memory address and presents the fetched instruction and PC+4 to ID, inserting a bubble on a taken branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on flush/boot (sll $0,$0,0).
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- PCSrc  input  1  branch unit: branch in ID is taken.
- BranchTarget  input  32  ID-computed target (PC+4 + signext(imm)<<2).
- InstrMemData  input  32  instruction memory read data, combinational from InstrMemAddr.
- InstrMemAddr  output  32  equals current PC.
- IF_ID_Instr  output  32  registered instruction to ID.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  0 = bubble in IF/ID.

Behaviour:
- Reset, asynchronous, while reset=1:
  - PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - State=BOOT.
- State machine, 2 states:
  - BOOT: first rising edge after reset deasserts. PC is held, IF/ID loads NOP_INSTR with Valid=0. Stall and PCSrc are ignored. Transitions to RUN.
  - RUN: steady state; never leaves except by reset.
- RUN, per rising edge, highest priority first:
  1. Stall=1: PC holds, IF/ID holds all fields. PCSrc is ignored, because ID operands are not yet valid; the branch re-evaluates next cycle.
  2. PCSrc=1: PC<=BranchTarget. IF/ID<=NOP_INSTR, PCPlus4<=0, Valid=0. This flushes the wrong-path instruction, giving a 1-cycle penalty.
  3. Otherwise: PC<=PC+4. IF/ID<=InstrMemData, PCPlus4<=PC+4, Valid=1.
- Arithmetic and address rules:
  - PC+4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 0, no flag.
  - BranchTarget is used as-is; bits [1:0] are forced to 0 when loaded into PC.
- Latency: InstrMemAddr tracks PC combinationally. The fetched word appears in IF/ID one edge later.
- Reset asserted mid-operation returns to reset values immediately (asynchronous), regardless of Stall or PCSrc.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - StallCount [CNT_W-1:0]: increments on every RUN edge with Stall=1.
  - FlushCount [CNT_W-1:0]: increments on every RUN edge with Stall=0 and PCSrc=1.
  - Both counters saturate at all-ones, clear on reset, and do not count in BOOT.
- When undefined, neither the ports nor the logic exist; the core behaviour is identical.

Test Plan:
- Reset and boot:
  - Stimulus: RESET_PC=0, hold reset 3 cycles, release, InstrMemData=32'h2008_0005.
  - Required response: after 1st edge Valid=0 and PC=0; after 2nd edge IF_ID_Instr=32'h2008_0005, PCPlus4=4, Valid=1, PC=4.
- Sequential fetch:
  - Stimulus: run 4 edges with no stall or branch.
  - Required response: InstrMemAddr goes 4, 8, 12, 16; IF_ID_PCPlus4 lags by one edge.
- Taken branch:
  - Stimulus: at PC=0x10, PCSrc=1, BranchTarget=0x40.
  - Required response: next edge PC=0x40, IF_ID_Instr=NOP_INSTR, Valid=0; following edge Valid=1, PCPlus4=0x44.
- Stall overrides branch:
  - Stimulus: PC=0x20, Stall=1 and PCSrc=1 for 2 edges, then Stall=0 with PCSrc=1 and target 0x80.
  - Required response: PC=0x20 and IF/ID unchanged for 2 edges, then PC=0x80 with a bubble.
- Wrap and alignment:
  - Stimulus: a branch to 0xFFFF_FFFE, then one sequential edge.
  - Required response: PC=0xFFFF_FFFC, then PC=0x0000_0000.
- With FETCH_PERF_CNT_EN, CNT_W=2:
  - Stimulus: 5 stall cycles and 2 flushes.
  - Required response: StallCount=3 (saturated), FlushCount=2.
- Async reset mid-run:
  - Stimulus: assert reset between edges.
  - Required response: outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage, PC + IF/ID register; FETCH_PERF_CNT_EN adds stall/flush counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PCSrc,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      InstrMemData,
    output logic [31:0]      InstrMemAddr,
    output logic [31:0]      IF_ID_Instr,
    output logic [31:0]      IF_ID_PCPlus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
`endif
    output logic             IF_ID_Valid
);
    typedef enum logic {BOOT, RUN} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_plus4, instr_n, pcp4_n;
    logic        valid_n, boot, hold, flush;
    assign InstrMemAddr = pc;
    assign pc_plus4     = pc + 32'd4;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= '0;
            IF_ID_Valid   <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            IF_ID_Instr   <= instr_n;
            IF_ID_PCPlus4 <= pcp4_n;
            IF_ID_Valid   <= valid_n;
        end
    end
    // Stall outranks PCSrc: branch operands are not yet valid while stalled
    always_comb begin
        state_n = RUN;
        boot    = state == BOOT;
        hold    = !boot && Stall;
        flush   = !boot && !Stall && PCSrc;
        pc_n    = (boot || hold) ? pc : flush ? {BranchTarget[31:2], 2'b00} : pc_plus4;
        instr_n = (boot || flush) ? NOP_INSTR : hold ? IF_ID_Instr : InstrMemData;
        pcp4_n  = (boot || flush) ? 32'd0 : hold ? IF_ID_PCPlus4 : pc_plus4;
        valid_n = (boot || flush) ? 1'b0 : hold ? IF_ID_Valid : 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (hold && StallCount != '1) StallCount <= StallCount + 1'b1;
            if (flush && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, Stall, PCSrc;
    logic [31:0] BranchTarget, InstrMemData, InstrMemAddr, IF_ID_Instr, IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    int          n_cmp = 0;
    int          n_err = 0;
`ifdef FETCH_PERF_CNT_EN
    logic [1:0]  StallCount, FlushCount;
`endif

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .InstrMemData(InstrMemData),
        .InstrMemAddr(InstrMemAddr), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_PCPlus4(IF_ID_PCPlus4),
`ifdef FETCH_PERF_CNT_EN
        .StallCount(StallCount), .FlushCount(FlushCount),
`endif
        .IF_ID_Valid(IF_ID_Valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'h8C00_0000);
    endfunction
    assign InstrMemData = imem(InstrMemAddr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v);
        chk({tag, ".pc"}, InstrMemAddr, pc);
        chk({tag, ".instr"}, IF_ID_Instr, ins);
        chk({tag, ".pcp4"}, IF_ID_PCPlus4, p4);
        chk({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        step();
        chk_if("boot", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk_if("first", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_if("seq", 32'h4 + 4 * i, imem(4 * i), 32'h4 + 4 * i, 1'b1);
        end
        PCSrc = 1'b1; BranchTarget = 32'h40;
        step();
        chk_if("br", 32'h40, 32'h0, 32'h0, 1'b0);
        PCSrc = 1'b0;
        step();
        chk_if("br_after", 32'h44, imem(32'h40), 32'h44, 1'b1);
        PCSrc = 1'b1; BranchTarget = 32'h1C;
        step();
        PCSrc = 1'b0;
        step();
        chk_if("pre_stall", 32'h20, imem(32'h1C), 32'h20, 1'b1);
        Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h80;
        repeat (2) begin
            step();
            chk_if("stall", 32'h20, imem(32'h1C), 32'h20, 1'b1);
        end
        Stall = 1'b0;
        step();
        chk_if("stall_br", 32'h80, 32'h0, 32'h0, 1'b0);
        BranchTarget = 32'hFFFF_FFFE;
        step();
        chk_if("align", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        PCSrc = 1'b0;
        step();
        chk_if("wrap", 32'h0, imem(32'hFFFF_FFFC), 32'h0, 1'b1);
        step();
        chk_if("post_wrap", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst.stall_cnt", {30'd0, StallCount}, 32'd0);
        chk("rst.flush_cnt", {30'd0, FlushCount}, 32'd0);
`endif
        step();
        Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h100;
        reset = 1'b0;
        step();
        chk_if("boot_ign", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("boot.stall_cnt", {30'd0, StallCount}, 32'd0);
        chk("boot.flush_cnt", {30'd0, FlushCount}, 32'd0);
`endif
        repeat (5) step();
        chk_if("stall5", 32'h0, 32'h0, 32'h0, 1'b0);
        Stall = 1'b0;
        step();
        chk("flush1.pc", InstrMemAddr, 32'h100);
        BranchTarget = 32'h200;
        step();
        chk("flush2.pc", InstrMemAddr, 32'h200);
        PCSrc = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("sat.stall_cnt", {30'd0, StallCount}, 32'd3);
        chk("sat.flush_cnt", {30'd0, FlushCount}, 32'd2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
